// File: rtl/ecc_scrub_err_logger.sv
// -----------------------------------------------------------------------------
// ecc_scrub_err_logger
//
// Error logger that sits behind the ECC scrubber output stage. It counts
// corrected and uncorrectable tag/data errors in saturating counters. It
// queues uncorrectable-error records in a small first-word-fall-through FIFO.
// It raises a level interrupt for software. Errors are only recorded here;
// nothing is corrected.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   scrub_*_i                     single-cycle error pulses from the scrubber
//   scrub_add_i                   data-bank address, valid with any pulse
//   clear_i                       synchronous clear of counters and overflow
//   *_cnt_o                       saturating error counters (registered)
//   log_valid_o / log_ready_i     FWFT FIFO head handshake
//   log_data_add_o, log_tag_add_o head record data address and tag index
//   log_is_tag_o, log_is_data_o   head record error-kind flags
//   overflow_o                    sticky: a record was dropped on a full FIFO
//   irq_o / irq_clear_i           level interrupt and its acknowledge
// -----------------------------------------------------------------------------
module ecc_scrub_err_logger #(
  parameter int unsigned DataDepth = 2048,
  parameter int unsigned TagDepth  = 256,
  parameter int unsigned LogDepth  = 4,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned DataAddrWidth = $clog2(DataDepth),
  localparam int unsigned TagAddrWidth  = $clog2(TagDepth)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     scrub_tag_bit_corrected_i,
  input  logic                     scrub_tag_uncorrectable_i,
  input  logic                     scrub_data_bit_corrected_i,
  input  logic                     scrub_data_uncorrectable_i,
  input  logic [DataAddrWidth-1:0] scrub_add_i,
  input  logic                     clear_i,
  output logic [CntWidth-1:0]      tag_corr_cnt_o,
  output logic [CntWidth-1:0]      tag_uncorr_cnt_o,
  output logic [CntWidth-1:0]      data_corr_cnt_o,
  output logic [CntWidth-1:0]      data_uncorr_cnt_o,
  output logic                     log_valid_o,
  input  logic                     log_ready_i,
  output logic [DataAddrWidth-1:0] log_data_add_o,
  output logic [TagAddrWidth-1:0]  log_tag_add_o,
  output logic                     log_is_tag_o,
  output logic                     log_is_data_o,
  output logic                     overflow_o,
  output logic                     irq_o,
  input  logic                     irq_clear_i
);

  localparam int unsigned IdxWidth = $clog2(LogDepth);
  localparam int unsigned PtrWidth = IdxWidth + 1;

  typedef struct packed {
    logic                     is_tag;
    logic                     is_data;
    logic [DataAddrWidth-1:0] add;
  } rec_t;

  // ---------------------------------------------------------------------------
  // Saturating counters
  // ---------------------------------------------------------------------------
  // A clear that coincides with an event leaves the counter at 1, so the event
  // is never lost.
  function automatic logic [CntWidth-1:0] cnt_next(
    input logic [CntWidth-1:0] cnt,
    input logic                inc,
    input logic                clr
  );
    if (clr) return {{(CntWidth-1){1'b0}}, inc};
    if (inc && (cnt != '1)) return cnt + CntWidth'(1);
    return cnt;
  endfunction

  logic [CntWidth-1:0] tag_corr_q,   tag_corr_d;
  logic [CntWidth-1:0] tag_uncorr_q, tag_uncorr_d;
  logic [CntWidth-1:0] data_corr_q,  data_corr_d;
  logic [CntWidth-1:0] data_uncorr_q, data_uncorr_d;

  assign tag_corr_d    = cnt_next(tag_corr_q,    scrub_tag_bit_corrected_i,  clear_i);
  assign tag_uncorr_d  = cnt_next(tag_uncorr_q,  scrub_tag_uncorrectable_i,  clear_i);
  assign data_corr_d   = cnt_next(data_corr_q,   scrub_data_bit_corrected_i, clear_i);
  assign data_uncorr_d = cnt_next(data_uncorr_q, scrub_data_uncorrectable_i, clear_i);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_corr_q    <= '0;
      tag_uncorr_q  <= '0;
      data_corr_q   <= '0;
      data_uncorr_q <= '0;
    end else begin
      tag_corr_q    <= tag_corr_d;
      tag_uncorr_q  <= tag_uncorr_d;
      data_corr_q   <= data_corr_d;
      data_uncorr_q <= data_uncorr_d;
    end
  end

  assign tag_corr_cnt_o    = tag_corr_q;
  assign tag_uncorr_cnt_o  = tag_uncorr_q;
  assign data_corr_cnt_o   = data_corr_q;
  assign data_uncorr_cnt_o = data_uncorr_q;

  // ---------------------------------------------------------------------------
  // Uncorrectable-error FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  // The pointers carry one extra wrap bit. Equal pointers mean the FIFO is
  // empty. Pointers that differ only in the wrap bit mean it is full.
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic                fifo_empty, fifo_full;
  logic                push_req, push_ok, pop, drop;
  rec_t                push_rec, head_rec;
  rec_t                mem_q [LogDepth];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrWidth-1] != rd_ptr_q[PtrWidth-1]) &&
                      (wr_ptr_q[IdxWidth-1:0] == rd_ptr_q[IdxWidth-1:0]);

  assign push_req = scrub_tag_uncorrectable_i | scrub_data_uncorrectable_i;
  assign pop      = ~fifo_empty & log_ready_i;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted when a pop happens with it.
  assign push_ok  = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  assign push_rec = '{is_tag:  scrub_tag_uncorrectable_i,
                      is_data: scrub_data_uncorrectable_i,
                      add:     scrub_add_i};

  assign wr_ptr_d = wr_ptr_q + PtrWidth'(push_ok);
  assign rd_ptr_d = rd_ptr_q + PtrWidth'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the record storage has no reset. The pointers alone decide validity,
  // and stale contents are masked off the outputs while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[IdxWidth-1:0]] <= push_rec;
  end

  assign head_rec       = mem_q[rd_ptr_q[IdxWidth-1:0]];
  assign log_valid_o    = ~fifo_empty;
  assign log_data_add_o = fifo_empty ? '0 : head_rec.add;
  assign log_is_tag_o   = ~fifo_empty & head_rec.is_tag;
  assign log_is_data_o  = ~fifo_empty & head_rec.is_data;
  assign log_tag_add_o  = log_data_add_o[DataAddrWidth-1 -: TagAddrWidth];

  // ---------------------------------------------------------------------------
  // Overflow flag and interrupt
  // ---------------------------------------------------------------------------
  logic overflow_q, overflow_d;
  logic irq_q, irq_d;

  // A drop in the same cycle as clear_i still sets the flag, so that drop is
  // not hidden.
  assign overflow_d = drop | (overflow_q & ~clear_i);
  // A new event takes priority over an acknowledge in the same cycle.
  assign irq_d      = (push_ok | drop) | (irq_q & ~irq_clear_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  assign overflow_o = overflow_q;
  assign irq_o      = irq_q;

  // ---------------------------------------------------------------------------
  // Simulation checks: the scrubber's check state lasts a single cycle, so no
  // source may pulse on two consecutive cycles.
  // ---------------------------------------------------------------------------
  a_log_depth_pow2: assert property (@(posedge clk_i)
    (LogDepth >= 2) && ((LogDepth & (LogDepth - 1)) == 0));
  a_tag_corr_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    scrub_tag_bit_corrected_i |=> !scrub_tag_bit_corrected_i);
  a_tag_uncorr_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    scrub_tag_uncorrectable_i |=> !scrub_tag_uncorrectable_i);
  a_data_corr_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    scrub_data_bit_corrected_i |=> !scrub_data_bit_corrected_i);
  a_data_uncorr_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    scrub_data_uncorrectable_i |=> !scrub_data_uncorrectable_i);

endmodule

// File: tb/tb_ecc_scrub_err_logger.sv
// -----------------------------------------------------------------------------
// tb_ecc_scrub_err_logger
//
// Self-checking bench for ecc_scrub_err_logger, built with 4-bit counters and
// a 4-entry log. Each uncorrectable record that the log is expected to accept
// goes into a scoreboard queue. The queue is popped and compared whenever the
// DUT hands a record to the consumer.
// -----------------------------------------------------------------------------
module tb_ecc_scrub_err_logger;

  localparam int unsigned DataDepth = 2048;
  localparam int unsigned TagDepth  = 256;
  localparam int unsigned LogDepth  = 4;
  localparam int unsigned CntWidth  = 4;
  localparam int unsigned AW        = 11;
  localparam int unsigned TW        = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          tag_corr_p, tag_unc_p, data_corr_p, data_unc_p;
  logic [AW-1:0] scrub_add;
  logic          clear, log_ready, irq_clear;
  logic [CntWidth-1:0] tag_corr_cnt, tag_uncorr_cnt, data_corr_cnt, data_uncorr_cnt;
  logic          log_valid, log_is_tag, log_is_data, overflow, irq;
  logic [AW-1:0] log_data_add;
  logic [TW-1:0] log_tag_add;

  int checks = 0;
  int errors = 0;

  // Scoreboard record: {is_tag, is_data, add}
  logic [AW+1:0] sb[$];
  logic          exp_ovf = 1'b0;

  ecc_scrub_err_logger #(
    .DataDepth(DataDepth), .TagDepth(TagDepth),
    .LogDepth(LogDepth),   .CntWidth(CntWidth)
  ) dut (
    .clk_i                      (clk_i),
    .rst_ni                     (rst_ni),
    .scrub_tag_bit_corrected_i  (tag_corr_p),
    .scrub_tag_uncorrectable_i  (tag_unc_p),
    .scrub_data_bit_corrected_i (data_corr_p),
    .scrub_data_uncorrectable_i (data_unc_p),
    .scrub_add_i                (scrub_add),
    .clear_i                    (clear),
    .tag_corr_cnt_o             (tag_corr_cnt),
    .tag_uncorr_cnt_o           (tag_uncorr_cnt),
    .data_corr_cnt_o            (data_corr_cnt),
    .data_uncorr_cnt_o          (data_uncorr_cnt),
    .log_valid_o                (log_valid),
    .log_ready_i                (log_ready),
    .log_data_add_o             (log_data_add),
    .log_tag_add_o              (log_tag_add),
    .log_is_tag_o               (log_is_tag),
    .log_is_data_o              (log_is_data),
    .overflow_o                 (overflow),
    .irq_o                      (irq),
    .irq_clear_i                (irq_clear)
  );

  always #5 clk_i = ~clk_i;

  // Drives one cycle of stimulus starting 1 time unit after a rising edge.
  // It updates the scoreboard and then returns 1 time unit after the next
  // rising edge with all pulses deasserted.
  task automatic step(input logic tc, input logic tu, input logic dc, input logic du,
                      input logic [AW-1:0] add, input logic rdy, input logic clr,
                      input logic iclr);
    logic [AW+1:0] exp;
    logic          pop;
    tag_corr_p  = tc;  tag_unc_p = tu;  data_corr_p = dc;  data_unc_p = du;
    scrub_add   = add; log_ready = rdy; clear       = clr; irq_clear = iclr;
    pop = log_valid & rdy;
    if (pop) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_pop_empty: DUT offered record %h but none was expected",
                 {log_is_tag, log_is_data, log_data_add});
      end else begin
        exp = sb.pop_front();
        if ({log_is_tag, log_is_data, log_data_add, log_tag_add} !== {exp, exp[AW-1 -: TW]}) begin
          errors++;
          $display("FAIL sb_head: got tag=%b data=%b add=%h tagadd=%h, expected %h",
                   log_is_tag, log_is_data, log_data_add, log_tag_add, exp);
        end
      end
    end
    if (tu | du) begin
      if (sb.size() < LogDepth) sb.push_back({tu, du, add});
      else exp_ovf = 1'b1;
    end else if (clr) begin
      exp_ovf = 1'b0;
    end
    @(posedge clk_i);
    #1;
    tag_corr_p = 0; tag_unc_p = 0; data_corr_p = 0; data_unc_p = 0;
    log_ready = 0; clear = 0; irq_clear = 0;
    checks++;
    if (log_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL sb_valid: log_valid_o=%b expected %b", log_valid, sb.size() != 0);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL sb_overflow: overflow_o=%b expected %b", overflow, exp_ovf);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_ni = 0;
    tag_corr_p = 0; tag_unc_p = 0; data_corr_p = 0; data_unc_p = 0;
    scrub_add = '0; clear = 0; log_ready = 0; irq_clear = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({tag_corr_cnt, tag_uncorr_cnt, data_corr_cnt, data_uncorr_cnt, log_valid,
         log_data_add, log_tag_add, log_is_tag, log_is_data, overflow, irq} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (valid=%b ovf=%b irq=%b)",
               log_valid, overflow, irq);
    end
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_corrected();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 11'h010, 0, 0, 0);
      idle();
    end
    checks++;
    if (data_corr_cnt !== 4'd3) begin
      errors++; $display("FAIL corr_count: data_corr_cnt_o=%0d expected 3", data_corr_cnt);
    end
    checks++;
    if ({log_valid, irq} !== 2'b00) begin
      errors++; $display("FAIL corr_no_log: valid=%b irq=%b expected 0 0", log_valid, irq);
    end
  endtask

  task automatic test_single_uncorr();
    step(0, 0, 0, 1, 11'h2A7, 0, 0, 0);
    checks++;
    if ({log_valid, log_data_add, log_tag_add, log_is_data, log_is_tag, irq} !==
        {1'b1, 11'h2A7, 8'h54, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_head: valid=%b add=%h tag=%h is_data=%b is_tag=%b irq=%b",
               log_valid, log_data_add, log_tag_add, log_is_data, log_is_tag, irq);
    end
    step(0, 0, 0, 0, '0, 0, 0, 1);
    checks++;
    if ({irq, log_valid} !== 2'b01) begin
      errors++; $display("FAIL irq_ack: irq=%b valid=%b expected 0 1", irq, log_valid);
    end
    step(0, 0, 0, 0, '0, 1, 0, 0);
    checks++;
    if (log_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: log_valid_o=%b expected 0", log_valid);
    end
  endtask

  task automatic test_dual();
    step(0, 0, 0, 0, '0, 0, 1, 1);
    checks++;
    if ({tag_corr_cnt, tag_uncorr_cnt, data_corr_cnt, data_uncorr_cnt} !== '0) begin
      errors++; $display("FAIL clear_only: counters not zero after clear_i");
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 11'h7FF, 0, 0, 0);
    checks++;
    if ({log_is_tag, log_is_data, log_tag_add, tag_uncorr_cnt, data_uncorr_cnt} !==
        {1'b1, 1'b1, 8'hFF, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL dual_rec: is_tag=%b is_data=%b tag=%h tcnt=%0d dcnt=%0d",
               log_is_tag, log_is_data, log_tag_add, tag_uncorr_cnt, data_uncorr_cnt);
    end
    step(0, 0, 0, 0, '0, 1, 0, 1);
    checks++;
    if ({log_valid, irq} !== 2'b00) begin
      errors++; $display("FAIL dual_single: valid=%b irq=%b expected 0 0", log_valid, irq);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 0, '0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 1, AW'(i), 0, 0, 0);
      if (i == 4) begin
        checks++;
        if ({overflow, log_data_add} !== {1'b0, 11'h001}) begin
          errors++; $display("FAIL full_no_ovf: ovf=%b head=%h expected 0 001", overflow, log_data_add);
        end
      end
      idle();
    end
    checks++;
    if ({overflow, irq} !== 2'b11) begin
      errors++; $display("FAIL overflow_set: ovf=%b irq=%b expected 1 1", overflow, irq);
    end
    step(0, 0, 0, 1, 11'h006, 1, 0, 0);
    checks++;
    if ({overflow, log_data_add} !== {1'b1, 11'h002}) begin
      errors++; $display("FAIL full_push_pop: ovf=%b head=%h expected 1 002", overflow, log_data_add);
    end
    checks++;
    if (data_uncorr_cnt !== 4'd6) begin
      errors++; $display("FAIL drop_counted: data_uncorr_cnt_o=%0d expected 6", data_uncorr_cnt);
    end
    step(0, 0, 0, 0, '0, 0, 1, 0);
    checks++;
    if ({overflow, data_uncorr_cnt, log_valid, log_data_add} !== {1'b0, 4'd0, 1'b1, 11'h002}) begin
      errors++;
      $display("FAIL clear_keeps_fifo: ovf=%b cnt=%0d valid=%b head=%h",
               overflow, data_uncorr_cnt, log_valid, log_data_add);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, 0, '0, 1, 0, 0);
    checks++;
    if ({log_valid, log_data_add, log_is_data} !== '0) begin
      errors++; $display("FAIL drained: valid=%b add=%h expected 0", log_valid, log_data_add);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 0, 0, '0, 0, 0, 0);
      idle();
    end
    checks++;
    if (tag_corr_cnt !== 4'd15) begin
      errors++; $display("FAIL saturate: tag_corr_cnt_o=%0d expected 15", tag_corr_cnt);
    end
    step(1, 0, 0, 0, '0, 0, 1, 0);
    checks++;
    if (tag_corr_cnt !== 4'd1) begin
      errors++; $display("FAIL clear_with_pulse: tag_corr_cnt_o=%0d expected 1", tag_corr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 0, '0, 0, 0, 1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_cleared: irq_o=%b expected 0", irq);
    end
    step(0, 0, 0, 1, 11'h100, 0, 0, 1);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_set_wins: irq_o=%b expected 1", irq);
    end
    step(0, 1, 0, 0, 11'h200, 0, 0, 0);
    checks++;
    if ({log_valid, log_data_add} !== {1'b1, 11'h100}) begin
      errors++; $display("FAIL two_queued: valid=%b head=%h expected 1 100", log_valid, log_data_add);
    end
    rst_ni = 0;
    #1;
    checks++;
    if ({tag_corr_cnt, tag_uncorr_cnt, data_corr_cnt, data_uncorr_cnt, log_valid,
         log_data_add, log_tag_add, log_is_tag, log_is_data, overflow, irq} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b add=%h irq=%b ovf=%b not all zero",
               log_valid, log_data_add, irq, overflow);
    end
    sb.delete();
    exp_ovf = 1'b0;
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
    idle();
  endtask

  initial begin
    test_reset();
    test_corrected();
    test_single_uncorr();
    test_dual();
    test_overflow();
    test_saturate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_err_logger.md
Name: ecc_scrub_err_logger

Overview:
- Sits directly downstream of the ECC scrubber output stage.
- Consumes its per-scrub error pulses (tag/data corrected/uncorrectable) together with the registered data-bank address of the checked line.
- Keeps saturating error counters and a first-word-fall-through (FWFT) FIFO of uncorrectable-error records.
- Raises a level interrupt for the cache controller / software; errors are recorded, never corrected here.

Parameters:
- DataDepth, 2048, depth of the data SRAM. DataAddrWidth = $clog2(DataDepth).
- TagDepth, 256, depth of the tag SRAM. TagAddrWidth = $clog2(TagDepth).
- LogDepth, 4, entries in the uncorrectable-error FIFO; power of two, ≥2.
- CntWidth, 16, width of each saturating counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- scrub_tag_bit_corrected_i  in  1  single-cycle pulse: tag single error found during scrub
- scrub_tag_uncorrectable_i  in  1  pulse: tag multi error
- scrub_data_bit_corrected_i  in  1  pulse: data single error
- scrub_data_uncorrectable_i  in  1  pulse: data multi error
- scrub_add_i  in  DataAddrWidth  data-bank address of the checked line; valid whenever any pulse is high
- clear_i  in  1  synchronous clear of all counters and the overflow flag
- tag_corr_cnt_o  out  CntWidth  tag corrected count
- tag_uncorr_cnt_o  out  CntWidth  tag uncorrectable count
- data_corr_cnt_o  out  CntWidth  data corrected count
- data_uncorr_cnt_o  out  CntWidth  data uncorrectable count
- log_valid_o  out  1  FIFO head valid
- log_ready_i  in  1  consumer pops head when valid&ready
- log_data_add_o  out  DataAddrWidth  head record data address
- log_tag_add_o  out  TagAddrWidth  head record tag index = log_data_add_o[DataAddrWidth-1 -: TagAddrWidth]
- log_is_tag_o  out  1  head record contains a tag uncorrectable error
- log_is_data_o  out  1  head record contains a data uncorrectable error
- overflow_o  out  1  sticky: a record was dropped because the FIFO was full
- irq_o  out  1  level interrupt
- irq_clear_i  in  1  acknowledge, clears irq_o

Behaviour:
- Reset (async): all counters 0, FIFO empty, log_valid_o=0, log_*_o=0, overflow_o=0, irq_o=0.
- Counters: each increments by 1 on the cycle its pulse is high.
  - Saturate at 2^CntWidth-1; no wrap.
  - Outputs are registered and update the cycle after the pulse.
  - clear_i with a simultaneous pulse: counter becomes 1; the event is never lost.
  - clear_i alone: counter becomes 0.
- Record push:
  - Occurs when scrub_tag_uncorrectable_i | scrub_data_uncorrectable_i.
  - Both pulses in one cycle produce ONE record with both flags set.
  - Record = {is_tag, is_data, scrub_add_i}.
  - Corrected-only events are counted but not logged.
- FIFO is FWFT: a record pushed in cycle N appears on log_* in cycle N+1 if the FIFO was empty.
  - Head is held stable while log_valid_o & ~log_ready_i.
  - Pop: log_valid_o & log_ready_i; the next entry (or valid=0) appears the following cycle.
  - log_ready_i while empty has no effect.
- Full:
  - Push with no pop: record dropped; overflow_o=1 from the next cycle, sticky until clear_i or reset.
  - Push and pop in the same cycle: push accepted, occupancy unchanged, no overflow.
- Empty with simultaneous push and pop: pop ignored (valid was 0), push accepted.
- Pointers: log2(LogDepth)+1 bits each; full/empty from the MSB compare; pointers wrap modulo 2*LogDepth.
- irq_o:
  - Set the cycle after any accepted push or any overflow event.
  - Cleared the cycle after irq_clear_i.
  - Set and clear in the same cycle: set wins (irq_o stays 1).
  - Independent of FIFO occupancy, so popping does not clear it.
- clear_i does not affect FIFO contents or irq_o.
- Inputs are already synchronous to clk_i; no retiming.
- Zero combinational path from any input to any output; all outputs are registered or driven directly from FIFO storage/pointers.
- Mid-operation reset discards all records immediately (async) and restores the reset values above.
- Simulation-only: assert that pulses are never high on two consecutive cycles for the same source (the scrubber's Check state is single-cycle); assert LogDepth is a power of two.

Test Plan (DataDepth=2048, TagDepth=256, LogDepth=4, CntWidth=4):
1. data_bit_corrected pulse ×3 with add=0x010 → data_corr_cnt_o=3, log_valid_o=0, irq_o=0.
2. data_uncorrectable with add=0x2A7 → next cycle log_valid_o=1, log_data_add_o=0x2A7, log_tag_add_o=0x54, log_is_data_o=1, log_is_tag_o=0, irq_o=1. irq_clear_i → irq_o=0 while log_valid_o stays 1. Pop → log_valid_o=0.
3. tag_uncorrectable and data_uncorrectable in the same cycle, add=0x7FF → one record with both flags set, tag_add=0xFF; tag_uncorr_cnt_o=1, data_uncorr_cnt_o=1.
4. 5 uncorrectable pushes, log_ready_i=0 → 4 records held (addresses 1..4), 5th dropped, overflow_o=1. Then push and pop in the same cycle while full → overflow_o unchanged, head becomes addr 2, tail = new record. clear_i → overflow_o=0, counters 0, FIFO keeps 4 records.
5. 17 tag_bit_corrected pulses → tag_corr_cnt_o saturates at 15. clear_i with a simultaneous pulse → tag_corr_cnt_o=1.
6. irq_clear_i coincident with a new push → irq_o stays 1. Assert rst_ni mid-stream with 2 records queued → all outputs 0 immediately.
